// File: rtl/daq_run_sequencer_if.sv
// Control/status bundle between the USB command side, DAQ control and the run sequencer.
// The master side issues run commands and cycle events; the slave side is the sequencer.
interface daq_run_sequencer_if;
   logic        RunStart;
   logic        RunStop;
   logic [15:0] RunCount;
   logic [15:0] IdleTime;
   logic [15:0] TimeoutLimit;
   logic        OnceEnd;
   logic        UsbFifoEmpty;
   logic        AcqStart;
   logic        RunBusy;
   logic        RunDone;
   logic [15:0] CycleCount;
   logic        TimeoutFlag;
   logic [2:0]  SeqState;

   modport master (
      output RunStart, RunStop, RunCount, IdleTime, TimeoutLimit, OnceEnd, UsbFifoEmpty,
      input  AcqStart, RunBusy, RunDone, CycleCount, TimeoutFlag, SeqState
   );

   modport slave (
      input  RunStart, RunStop, RunCount, IdleTime, TimeoutLimit, OnceEnd, UsbFifoEmpty,
      output AcqStart, RunBusy, RunDone, CycleCount, TimeoutFlag, SeqState
   );
endinterface

// File: rtl/daq_run_sequencer.sv
// DAQ run sequencer: repeats acquire/drain/gap cycles for one run and reports progress.
// Defining DAQ_SEQ_TIMEOUT_EN adds a watchdog on cycles stalled in WAIT_END/DRAIN.
module daq_run_sequencer (
   input logic                Clk,
   input logic                reset,
   daq_run_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      WAIT_END = 3'd2,
      DRAIN    = 3'd3,
      GAP      = 3'd4,
      DONE     = 3'd5
   } seqState_t;

   seqState_t   state;
   seqState_t   nextState;
   logic [15:0] cycleCount;
   logic [15:0] gapCount;
   logic        stopPending;
   logic        acqStartReg;
   logic        runBusyReg;
   logic        runDoneReg;
   logic        startAccept;
   logic        cycleInc;
   logic        setStopPending;
   logic        timeoutHit;
   logic        wdExpire;

   // Next-state decode; a completed cycle outranks a watchdog expiry in the same clock.
   always_comb begin
      nextState      = state;
      startAccept    = 1'b0;
      cycleInc       = 1'b0;
      setStopPending = 1'b0;
      timeoutHit     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.RunStart && !bus.RunStop) begin
               nextState   = START;
               startAccept = 1'b1;
            end
         end
         START: begin
            nextState = bus.RunStop ? DONE : WAIT_END;
         end
         WAIT_END: begin
            setStopPending = bus.RunStop;
            if (bus.OnceEnd) begin
               nextState = DRAIN;
               cycleInc  = 1'b1;
            end else if (wdExpire) begin
               nextState  = DONE;
               timeoutHit = 1'b1;
            end
         end
         DRAIN: begin
            setStopPending = bus.RunStop;
            if (bus.UsbFifoEmpty) begin
               if (stopPending || bus.RunStop ||
                   ((bus.RunCount != 16'd0) && (cycleCount == bus.RunCount)))
                  nextState = DONE;
               else
                  nextState = GAP;
            end else if (wdExpire) begin
               nextState  = DONE;
               timeoutHit = 1'b1;
            end
         end
         GAP: begin
            if (bus.RunStop)
               nextState = DONE;
            else if (gapCount <= 16'd1)
               nextState = START;
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register plus outputs registered from the next state so they align with it.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cycleCount  <= 16'd0;
         gapCount    <= 16'd0;
         stopPending <= 1'b0;
         acqStartReg <= 1'b0;
         runBusyReg  <= 1'b0;
         runDoneReg  <= 1'b0;
      end else begin
         state       <= nextState;
         acqStartReg <= (nextState == START) || (nextState == WAIT_END);
         runBusyReg  <= (nextState != IDLE);
         runDoneReg  <= (nextState == DONE);
         if (startAccept) begin
            cycleCount  <= 16'd0;
            stopPending <= 1'b0;
         end else begin
            if (cycleInc && (cycleCount != 16'hFFFF))
               cycleCount <= cycleCount + 16'd1;
            if (setStopPending)
               stopPending <= 1'b1;
         end
         // Loading IdleTime on entry gives a GAP of max(IdleTime,1) clocks.
         if ((nextState == GAP) && (state != GAP))
            gapCount <= bus.IdleTime;
         else if (state == GAP)
            gapCount <= gapCount - 16'd1;
      end
   end

`ifdef DAQ_SEQ_TIMEOUT_EN
   logic [23:0] wdCount;
   logic [23:0] wdLimit;
   logic        timeoutFlag;

   assign wdLimit  = {bus.TimeoutLimit, 8'h00};
   assign wdExpire = (bus.TimeoutLimit != 16'd0) && (wdCount == (wdLimit - 24'd1));

   // Watchdog sits at zero outside the cycle so every WAIT_END entry starts fresh.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         wdCount     <= 24'd0;
         timeoutFlag <= 1'b0;
      end else begin
         if ((state == WAIT_END) || (state == DRAIN))
            wdCount <= wdCount + 24'd1;
         else
            wdCount <= 24'd0;
         if (startAccept)
            timeoutFlag <= 1'b0;
         else if (timeoutHit)
            timeoutFlag <= 1'b1;
      end
   end

   assign bus.TimeoutFlag = timeoutFlag;
`else
   logic unusedTimeout;

   assign wdExpire        = 1'b0;
   assign unusedTimeout   = ^{bus.TimeoutLimit, timeoutHit};
   assign bus.TimeoutFlag = 1'b0;
`endif

   assign bus.AcqStart   = acqStartReg;
   assign bus.RunBusy    = runBusyReg;
   assign bus.RunDone    = runDoneReg;
   assign bus.CycleCount = cycleCount;
   assign bus.SeqState   = state;

endmodule

// File: doc/daq_run_sequencer.md
DAQ_RUN_SEQUENCER -- requirements
Module: daq_run_sequencer

Interface
REQ-001 SHALL have port Clk  input  1  system clock, 40 MHz, all logic on rising edge.
REQ-002 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port RunStart  input  1  one-clock pulse from USB command decoder; requests a run.
REQ-004 SHALL have port RunStop  input  1  one-clock pulse; requests run abort.
REQ-005 SHALL have port RunCount  input  16  acquisition cycles per run; 0 = unlimited.
REQ-006 SHALL have port IdleTime  input  16  gap between cycles, in Clk periods.
REQ-007 SHALL have port TimeoutLimit  input  16  watchdog limit, in units of 256 Clk periods.
REQ-008 SHALL have port OnceEnd  input  1  one-clock pulse from DAQ control; one acquisition plus readout finished.
REQ-009 SHALL have port UsbFifoEmpty  input  1  level; USB FIFO drained.
REQ-010 SHALL have port AcqStart  output  1  registered level to DAQ control UsbAcqStart.
REQ-011 SHALL have port RunBusy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port RunDone  output  1  one-clock pulse at run end.
REQ-013 SHALL have port CycleCount  output  16  completed cycles in current or last run.
REQ-014 SHALL have port TimeoutFlag  output  1  sticky; watchdog expired in last run.
REQ-015 SHALL have port SeqState  output  3  current state code for debug register.

Function
REQ-016 SHALL implement states IDLE=0, START=1, WAIT_END=2, DRAIN=3, GAP=4, DONE=5; codes 6 and 7 SHALL return to IDLE on the next clock.
REQ-017 In IDLE, a RunStart SHALL move to START on the next edge, clear CycleCount, TimeoutFlag and stop-pending.
REQ-018 RunStart outside IDLE SHALL be ignored; simultaneous RunStart and RunStop in IDLE SHALL leave the block in IDLE.
REQ-019 AcqStart SHALL be high exactly while the state is START or WAIT_END, so it rises one clock after the accepted RunStart.
REQ-020 START SHALL last one clock, then go to WAIT_END.
REQ-021 In WAIT_END, OnceEnd SHALL increment CycleCount (saturating at 0xFFFF) and move to DRAIN.
REQ-022 In DRAIN, UsbFifoEmpty high SHALL end the cycle.
  - Go to DONE if stop-pending is set, or if RunCount != 0 and CycleCount == RunCount.
  - Otherwise go to GAP.
REQ-023 GAP SHALL count IdleTime clocks and then go to START; IdleTime = 0 SHALL go to START on the next clock.
REQ-024 RunStop in START or GAP SHALL go to DONE on the next edge.
REQ-025 RunStop in WAIT_END or DRAIN SHALL set stop-pending; the current cycle SHALL complete before DONE.
REQ-026 DONE SHALL last one clock with RunDone high, then go to IDLE; CycleCount and TimeoutFlag SHALL hold until the next accepted RunStart.
REQ-027 Watchdog: a 24-bit counter SHALL clear on entry to WAIT_END and run while in WAIT_END or DRAIN.
  - When the count reaches TimeoutLimit*256, set TimeoutFlag and go to DONE.
  - TimeoutLimit = 0 SHALL disable the watchdog.
REQ-028 OnceEnd SHALL take priority over a watchdog expiry in the same cycle; RunStop and expiry in the same cycle SHALL produce DONE with TimeoutFlag set.

Reset
REQ-029 While reset is high, all outputs and counters SHALL be forced to these values asynchronously:
  - state IDLE, AcqStart 0, RunBusy 0, RunDone 0, CycleCount 0, TimeoutFlag 0, stop-pending 0.
REQ-030 Reset asserted mid-run SHALL drop AcqStart immediately; after release the block SHALL wait in IDLE for a new RunStart.

Configuration
REQ-031 Macro DAQ_SEQ_TIMEOUT_EN SHALL control the watchdog.
  - Defined: watchdog per REQ-027/028.
  - Undefined: watchdog logic is absent, TimeoutLimit is ignored, TimeoutFlag is tied to 0, and WAIT_END/DRAIN wait indefinitely.

Verification
REQ-032 RunCount=3, IdleTime=10, OnceEnd 50 clocks after each AcqStart rise, FIFO empty 20 clocks later -> three AcqStart windows separated by 10-clock gaps, CycleCount=3, one RunDone, RunBusy low after it.
REQ-033 RunCount=0, RunStop asserted during the 5th WAIT_END -> 5th cycle completes through DRAIN, then RunDone; CycleCount=5.
REQ-034 With macro defined, TimeoutLimit=2, OnceEnd never arrives -> DONE 512 clocks after WAIT_END entry; TimeoutFlag=1, CycleCount=0, AcqStart low.
REQ-035 With macro defined, OnceEnd in the same clock as watchdog expiry -> CycleCount increments, state goes to DRAIN, TimeoutFlag stays 0.
REQ-036 reset asserted in GAP of cycle 2 -> all outputs 0 immediately; RunStart after release starts a fresh run with CycleCount cleared.
REQ-037 Simultaneous RunStart and RunStop in IDLE -> state remains 0, AcqStart never rises.
